// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the round-robin stream mux
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2 with a floor of 1 so a select field is never zero-width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// rtl/mux_rr_stream_if.sv - N-channel input bundle plus single output stream
interface mux_rr_stream_if #(
  parameter int N_IN  = 5,
  parameter int WIDTH = 8
);
  import mux_pkg::*;

  localparam int SEL_W = clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  force_en;
  logic [SEL_W-1:0]      force_sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_sel;

  // Producers/consumer side.
  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request searching upward from base+1 with wrap
module rr_pick #(
  parameter int N     = 5,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Walk N positions starting just after base; the first requester wins.
  always_comb begin
    int i;
    i     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      i = (int'(base) + k) % N;
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = i[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-to-1 arbitrated stream mux with registered output
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_RR
) (
  input logic           clk,
  input logic           reset,
  mux_rr_stream_if.slave bus
);

  localparam int SEL_W = clog2(N_IN);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] gidx;
  logic [N_IN-1:0]  elig;
  logic [N_IN-1:0]  grant;
  logic             any;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] word;

  // Restrict candidates to the forced channel; an out-of-range force selects nothing.
  always_comb begin
    elig = bus.in_valid;
    if (bus.force_en) begin
      elig = '0;
      if (int'(bus.force_sel) < N_IN) begin
        elig = bus.in_valid & (N_IN'(1) << bus.force_sel);
      end
    end
  end

  // Fixed priority is round-robin with the base pinned so channel 0 is searched first.
  assign base     = (MODE == MODE_FIXED) ? SEL_W'(N_IN - 1) : ptr;
  assign can_load = !bus.out_valid || bus.out_ready;
  assign xfer     = can_load && any && !reset;

  rr_pick #(
    .N     (N_IN),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (elig),
    .base  (base),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign bus.in_ready = xfer ? grant : '0;
  assign word         = bus.in_data[int'(gidx)*WIDTH +: WIDTH];

  // One-entry output buffer and round-robin pointer; a new load replaces a draining word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= SEL_W'(N_IN - 1);
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= word;
      bus.out_sel   <= gidx;
      ptr           <= gidx;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - scoreboard bench for round-robin and fixed-priority muxes
module tb_mux_rr_stream;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  exp_t q1[$];
  exp_t q0[$];

  localparam logic [39:0] DWORDS = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};

  mux_rr_stream_if #(.N_IN(5), .WIDTH(8)) if1 ();
  mux_rr_stream_if #(.N_IN(5), .WIDTH(8)) if0 ();

  mux_rr_stream #(.N_IN(5), .WIDTH(8), .MODE(1)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  mux_rr_stream #(.N_IN(5), .WIDTH(8), .MODE(0)) u_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitors: pop and compare whenever an output word is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rr_unexpected: got sel %0d data %0h expected no word", if1.out_sel, if1.out_data);
        end else begin
          e = q1.pop_front();
          check("rr_out_sel", 64'(if1.out_sel), 64'(e.sel));
          check("rr_out_data", 64'(if1.out_data), 64'(e.data));
        end
      end
      if (if0.out_valid && if0.out_ready) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL fx_unexpected: got sel %0d data %0h expected no word", if0.out_sel, if0.out_data);
        end else begin
          e = q0.pop_front();
          check("fx_out_sel", 64'(if0.out_sel), 64'(e.sel));
          check("fx_out_data", 64'(if0.out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rr_exp[6];
    rr_exp = '{0, 1, 2, 3, 4, 0};
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    if1.in_data = DWORDS; if1.in_valid = '0; if1.force_en = 1'b0; if1.force_sel = '0; if1.out_ready = 1'b1;
    if0.in_data = DWORDS; if0.in_valid = '0; if0.force_en = 1'b0; if0.force_sel = '0; if0.out_ready = 1'b1;

    // Reset state, with requests present that must not be acknowledged.
    #3;
    if1.in_valid = 5'h1f;
    #1;
    check("rst_valid", 64'(if1.out_valid), 64'd0);
    check("rst_data", 64'(if1.out_data), 64'd0);
    check("rst_sel", 64'(if1.out_sel), 64'd0);
    check("rst_ready", 64'(if1.in_ready), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    if1.in_valid = '0;

    // Round-robin sweep with all channels requesting.
    cyc();
    if1.in_valid = 5'h1f;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 64'(if1.in_ready), 64'(1) << rr_exp[k]);
      q1.push_back('{sel: 3'(rr_exp[k]), data: 8'(8'h10 + rr_exp[k])});
      cyc();
    end
    if1.in_valid = '0;
    cyc();
    cyc();
    #1;
    check("rr_idle_valid", 64'(if1.out_valid), 64'd0);
    check("rr_idle_data", 64'(if1.out_data), 64'd0);

    // Fixed priority: channel 0 always wins.
    if0.in_valid = 5'h1f;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fx_ready", 64'(if0.in_ready), 64'd1);
      q0.push_back('{sel: 3'd0, data: 8'h10});
      cyc();
    end
    if0.in_valid = '0;
    cyc();
    cyc();
    #1;
    check("fx_idle_valid", 64'(if0.out_valid), 64'd0);

    // Backpressure after a fresh reset.
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    if1.out_ready = 1'b0;
    if1.in_valid = 5'h1f;
    #1;
    check("bp_first_ready", 64'(if1.in_ready), 64'd1);
    q1.push_back('{sel: 3'd0, data: 8'h10});
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_hold_ready", 64'(if1.in_ready), 64'd0);
      check("bp_hold_data", 64'(if1.out_data), 64'h10);
      check("bp_hold_valid", 64'(if1.out_valid), 64'd1);
      cyc();
    end
    if1.out_ready = 1'b1;
    #1;
    check("bp_next_ready", 64'(if1.in_ready), 64'd2);
    q1.push_back('{sel: 3'd1, data: 8'h11});
    cyc();
    if1.in_valid = '0;
    cyc();
    cyc();

    // Forced select, then an out-of-range force.
    if1.force_en = 1'b1;
    if1.force_sel = 3'd3;
    if1.in_valid = 5'h1f;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("force_ready", 64'(if1.in_ready), 64'h8);
      q1.push_back('{sel: 3'd3, data: 8'h13});
      cyc();
    end
    if1.force_sel = 3'd6;
    #1;
    check("force_oor_ready", 64'(if1.in_ready), 64'd0);
    cyc();
    cyc();
    #1;
    check("force_oor_valid", 64'(if1.out_valid), 64'd0);
    check("force_oor_data", 64'(if1.out_data), 64'd0);
    check("force_oor_sel", 64'(if1.out_sel), 64'd0);

    // Reset while a word is held in the output register.
    cyc();
    if1.force_sel = 3'd2;
    if1.out_ready = 1'b0;
    #1;
    check("ms_ready", 64'(if1.in_ready), 64'h4);
    cyc();
    #1;
    check("ms_held_data", 64'(if1.out_data), 64'h12);
    reset = 1'b1;
    #1;
    check("ms_rst_valid", 64'(if1.out_valid), 64'd0);
    check("ms_rst_data", 64'(if1.out_data), 64'd0);
    check("ms_rst_sel", 64'(if1.out_sel), 64'd0);
    check("ms_rst_ready", 64'(if1.in_ready), 64'd0);
    cyc();
    reset = 1'b0;
    if1.force_en = 1'b0;
    if1.out_ready = 1'b1;
    #1;
    check("ms_after_ready", 64'(if1.in_ready), 64'd1);
    q1.push_back('{sel: 3'd0, data: 8'h10});
    cyc();
    if1.in_valid = '0;
    cyc();
    cyc();
    #1;
    check("end_rr_queue", 64'(q1.size()), 64'd0);
    check("end_fx_queue", 64'(q0.size()), 64'd0);
    check("end_valid", 64'(if1.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
